// File: rtl/tff_multimode_counter_if.sv
// Control/status bundle for the multimode T-flip-flop counter: switches in, LED state out.
interface tff_multimode_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] t_mask;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             tc;

  modport master (output en, mode, load, load_val, t_mask, input q, q_bar, tc);
  modport slave  (input en, mode, load, load_val, t_mask, output q, q_bar, tc);
endinterface

// File: rtl/tff_multimode_counter.sv
// Bank of T flip-flops driven by a shared next-state controller: hold, modulo up/down,
// raw toggle mask, parallel load and a registered terminal-count pulse.
module tff_multimode_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter bit SATURATE = 1'b0
) (
  input logic                    clk,
  input logic                    rst,
  tff_multimode_counter_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_e;

  // One extra bit so MODULUS = 2**WIDTH still has a representable limit compare.
  localparam logic [WIDTH:0]   LIMIT_W = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LIMIT   = LIMIT_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1'b1);

  logic [WIDTH-1:0] q_r;
  logic             tc_r;
  logic [WIDTH-1:0] q_next_s;
  logic [WIDTH-1:0] t_s;
  logic             tc_next_s;
  logic             at_top_s;
  logic             above_top_s;
  logic             load_over_s;

  // Next-state controller: load beats enable, modulus limits applied in up/down modes.
  always_comb begin
    q_next_s    = q_r;
    tc_next_s   = 1'b0;
    at_top_s    = ({1'b0, q_r} >= LIMIT_W);
    above_top_s = ({1'b0, q_r} > LIMIT_W);
    load_over_s = ({1'b0, bus.load_val} > LIMIT_W);
    if (bus.load) begin
      if (load_over_s) begin
        q_next_s = LIMIT;
      end else begin
        q_next_s = bus.load_val;
      end
    end else if (bus.en) begin
      case (mode_e'(bus.mode))
        MODE_HOLD: begin
          q_next_s = q_r;
        end
        MODE_UP: begin
          if (at_top_s) begin
            q_next_s  = SATURATE ? LIMIT : ZERO;
            tc_next_s = (q_r == LIMIT);
          end else begin
            q_next_s = q_r + ONE;
          end
        end
        MODE_DOWN: begin
          if (q_r == ZERO) begin
            q_next_s  = SATURATE ? ZERO : LIMIT;
            tc_next_s = 1'b1;
          end else if (above_top_s) begin
            q_next_s = LIMIT;
          end else begin
            q_next_s = q_r - ONE;
          end
        end
        MODE_TOGGLE: begin
          q_next_s = q_r ^ bus.t_mask;
        end
        default: begin
          q_next_s = q_r;
        end
      endcase
    end else begin
      q_next_s = q_r;
    end
  end

  // The cells only see toggle enables; the controller's target is folded into t.
  assign t_s = q_r ^ q_next_s;

  // T-cell bank and terminal-count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r  <= ZERO;
      tc_r <= 1'b0;
    end else begin
      q_r  <= q_r ^ t_s;
      tc_r <= tc_next_s;
    end
  end

  assign bus.q     = q_r;
  assign bus.q_bar = ~q_r;
  assign bus.tc    = tc_r;

endmodule

// File: tb/tb_tff_multimode_counter.sv
// Table-driven scoreboard bench for tff_multimode_counter over three parameter sets.
module tb_tff_multimode_counter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tff_multimode_counter_if #(.WIDTH(8)) if_a ();
  tff_multimode_counter_if #(.WIDTH(4)) if_b ();
  tff_multimode_counter_if #(.WIDTH(4)) if_c ();

  tff_multimode_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));
  tff_multimode_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));
  tff_multimode_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c.slave));

  typedef struct {
    int       dut;
    bit       rst;
    bit       en;
    bit [1:0] mode;
    bit       load;
    int       lv;
    int       tm;
    int       exp_q;
    bit       exp_tc;
    string    name;
  } vec_t;

  typedef struct {
    int    dut;
    int    exp_q;
    bit    exp_tc;
    string name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(int d, bit r, bit en, bit [1:0] m, bit ld, int lv, int tm,
                              int eq, bit etc, string n);
    vec_t v;
    v.dut = d; v.rst = r; v.en = en; v.mode = m; v.load = ld;
    v.lv = lv; v.tm = tm; v.exp_q = eq; v.exp_tc = etc; v.name = n;
    return v;
  endfunction

  function automatic void add(int d, bit r, bit en, bit [1:0] m, bit ld, int lv, int tm,
                              int eq, bit etc, string n);
    vecs.push_back(mk(d, r, en, m, ld, lv, tm, eq, etc, n));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sample(input int d, output int q, output int qb, output int tc);
    case (d)
      0: begin q = int'(if_a.q); qb = int'(if_a.q_bar); tc = int'(if_a.tc); end
      1: begin q = int'(if_b.q); qb = int'(if_b.q_bar); tc = int'(if_b.tc); end
      default: begin q = int'(if_c.q); qb = int'(if_c.q_bar); tc = int'(if_c.tc); end
    endcase
  endtask

  task automatic idle_all();
    if_a.en = 1'b0; if_a.load = 1'b0; if_a.mode = 2'b00; if_a.load_val = 8'h00; if_a.t_mask = 8'h00;
    if_b.en = 1'b0; if_b.load = 1'b0; if_b.mode = 2'b00; if_b.load_val = 4'h0; if_b.t_mask = 4'h0;
    if_c.en = 1'b0; if_c.load = 1'b0; if_c.mode = 2'b00; if_c.load_val = 4'h0; if_c.t_mask = 4'h0;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    int   q, qb, tc, mask;
    idle_all();
    rst = v.rst;
    case (v.dut)
      0: begin if_a.en = v.en; if_a.mode = v.mode; if_a.load = v.load;
               if_a.load_val = 8'(v.lv); if_a.t_mask = 8'(v.tm); end
      1: begin if_b.en = v.en; if_b.mode = v.mode; if_b.load = v.load;
               if_b.load_val = 4'(v.lv); if_b.t_mask = 4'(v.tm); end
      default: begin if_c.en = v.en; if_c.mode = v.mode; if_c.load = v.load;
               if_c.load_val = 4'(v.lv); if_c.t_mask = 4'(v.tm); end
    endcase
    sb.push_back('{v.dut, v.exp_q, v.exp_tc, v.name});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    mask = (e.dut == 0) ? 255 : 15;
    sample(e.dut, q, qb, tc);
    check({e.name, ".q"}, q, e.exp_q);
    check({e.name, ".q_bar"}, qb, (~e.exp_q) & mask);
    check({e.name, ".tc"}, tc, int'(e.exp_tc));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q, qb, tc;
    rst = 1'b1;
    idle_all();

    // Reset state of all three banks.
    apply(mk(0, 1'b1, 1'b0, 2'b00, 1'b0, 0, 0, 0, 1'b0, "reset_a"));
    sample(1, q, qb, tc);
    check("reset_b.q", q, 0); check("reset_b.q_bar", qb, 15); check("reset_b.tc", tc, 0);
    sample(2, q, qb, tc);
    check("reset_c.q", q, 0); check("reset_c.q_bar", qb, 15); check("reset_c.tc", tc, 0);

    // Full 8-bit up sweep with wrap.
    for (int i = 0; i < 256; i++)
      add(0, 1'b0, 1'b1, 2'b01, 1'b0, 0, 0, (i + 1) % 256, (i == 255), "up256_a");

    // Mod-10 wrap-down, tc on 0->9, and load clamp.
    add(1, 1'b0, 1'b0, 2'b00, 1'b1, 9, 0, 9, 1'b0, "load9_b");
    for (int k = 0; k < 9; k++)
      add(1, 1'b0, 1'b1, 2'b10, 1'b0, 0, 0, 8 - k, 1'b0, "down_b");
    add(1, 1'b0, 1'b1, 2'b10, 1'b0, 0, 0, 9, 1'b1, "wrap_down_b");
    add(1, 1'b0, 1'b1, 2'b10, 1'b0, 0, 0, 8, 1'b0, "down_after_wrap_b");
    add(1, 1'b0, 1'b0, 2'b00, 1'b1, 15, 0, 9, 1'b0, "load_clamp_b");

    // Saturating limits keep pulsing tc.
    add(2, 1'b0, 1'b0, 2'b00, 1'b1, 9, 0, 9, 1'b0, "load9_c");
    for (int k = 0; k < 3; k++)
      add(2, 1'b0, 1'b1, 2'b01, 1'b0, 0, 0, 9, 1'b1, "sat_up_c");
    add(2, 1'b0, 1'b0, 2'b01, 1'b0, 0, 0, 9, 1'b0, "idle_c");
    add(2, 1'b0, 1'b0, 2'b00, 1'b1, 0, 0, 0, 1'b0, "load0_c");
    for (int k = 0; k < 2; k++)
      add(2, 1'b0, 1'b1, 2'b10, 1'b0, 0, 0, 0, 1'b1, "sat_down_c");

    // Toggle mask and out-of-range recovery.
    add(1, 1'b0, 1'b0, 2'b00, 1'b1, 0, 0, 0, 1'b0, "load0_b");
    add(1, 1'b0, 1'b1, 2'b11, 1'b0, 0, 10, 10, 1'b0, "toggle1_b");
    add(1, 1'b0, 1'b1, 2'b11, 1'b0, 0, 10, 0, 1'b0, "toggle2_b");
    add(1, 1'b0, 1'b1, 2'b11, 1'b0, 0, 12, 12, 1'b0, "toggle12_b");
    add(1, 1'b0, 1'b1, 2'b01, 1'b0, 0, 0, 0, 1'b0, "oor_up_b");
    add(1, 1'b0, 1'b1, 2'b11, 1'b0, 0, 12, 12, 1'b0, "toggle12_again_b");
    add(1, 1'b0, 1'b1, 2'b10, 1'b0, 0, 0, 9, 1'b0, "oor_down_b");
    add(1, 1'b0, 1'b0, 2'b11, 1'b0, 0, 15, 9, 1'b0, "toggle_no_en_b");
    add(2, 1'b0, 1'b1, 2'b11, 1'b0, 0, 12, 12, 1'b0, "toggle12_c");
    add(2, 1'b0, 1'b1, 2'b01, 1'b0, 0, 0, 9, 1'b0, "oor_up_sat_c");

    // Priority rst > load > en.
    add(1, 1'b1, 1'b1, 2'b01, 1'b1, 5, 0, 0, 1'b0, "rst_prio_b");
    add(1, 1'b0, 1'b0, 2'b00, 1'b1, 5, 0, 5, 1'b0, "load_no_en_b");
    add(1, 1'b0, 1'b1, 2'b00, 1'b0, 0, 0, 5, 1'b0, "hold_en1_b");
    add(1, 1'b0, 1'b0, 2'b00, 1'b0, 0, 0, 5, 1'b0, "hold_en0_b");
    add(1, 1'b0, 1'b1, 2'b00, 1'b0, 0, 0, 5, 1'b0, "hold_en1_again_b");
    add(1, 1'b0, 1'b1, 2'b01, 1'b1, 3, 0, 3, 1'b0, "load_over_en_b");

    foreach (vecs[i]) apply(vecs[i]);

    // Reset in the middle of an up count, then resume.
    apply(mk(0, 1'b0, 1'b0, 2'b00, 1'b1, 6, 0, 6, 1'b0, "load6_a"));
    apply(mk(0, 1'b0, 1'b1, 2'b01, 1'b0, 0, 0, 7, 1'b0, "up7_a"));
    apply(mk(0, 1'b1, 1'b1, 2'b01, 1'b0, 0, 0, 0, 1'b0, "mid_rst_a"));
    apply(mk(0, 1'b0, 1'b1, 2'b01, 1'b0, 0, 0, 1, 1'b0, "resume1_a"));
    apply(mk(0, 1'b0, 1'b1, 2'b01, 1'b0, 0, 0, 2, 1'b0, "resume2_a"));

    // Reset clears a pending tc and beats a load.
    apply(mk(2, 1'b0, 1'b0, 2'b00, 1'b1, 9, 0, 9, 1'b0, "reload9_c"));
    apply(mk(2, 1'b0, 1'b1, 2'b01, 1'b0, 0, 0, 9, 1'b1, "tc_before_rst_c"));
    apply(mk(2, 1'b1, 1'b1, 2'b01, 1'b1, 5, 0, 0, 1'b0, "rst_clears_tc_c"));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
